// File: rtl/can_stuff_engine_if.sv
// Framer/bit-timing side bundle for the CAN stuffing engine.
// master = framer and bus logic, slave = stuffing engine.
interface can_stuff_if;
  logic       enable;
  logic       sample;
  logic       tx_mode;
  logic       fixed_mode;
  logic       tx_bit;
  logic       rx_bit;
  logic       tx_bus;
  logic       tx_take;
  logic       rx_data;
  logic       rx_valid;
  logic       stuff_bit;
  logic       stuff_err;
  logic [2:0] stuff_cnt;

  modport master (
    output enable, sample, tx_mode, fixed_mode,
    output tx_bit, rx_bit,
    input  tx_bus, tx_take, rx_data, rx_valid,
    input  stuff_bit, stuff_err, stuff_cnt
  );

  modport slave (
    input  enable, sample, tx_mode, fixed_mode,
    input  tx_bit, rx_bit,
    output tx_bus, tx_take, rx_data, rx_valid,
    output stuff_bit, stuff_err, stuff_cnt
  );
endinterface

// File: rtl/can_stuff_engine.sv
// CAN bit stuffing engine: dynamic and FD fixed stuffing on TX,
// destuffing with stuff error detection on RX, stuff count mod 8.
module can_stuff_engine #(
  parameter int STUFF_LEN = 5,
  parameter int FIXED_LEN = 4
) (
  input logic        clock,
  input logic        reset_n,
  can_stuff_if.slave bus
);
  localparam int RW = $clog2(STUFF_LEN + 2);
  localparam int FW = $clog2(FIXED_LEN + 1);
  localparam logic [RW-1:0] RLIM = RW'(STUFF_LEN);
  localparam logic [RW-1:0] RMAX = RW'(STUFF_LEN + 1);
  localparam logic [RW-1:0] RONE = RW'(1);
  localparam logic [FW-1:0] FLIM = FW'(FIXED_LEN);
  localparam logic [FW-1:0] FONE = FW'(1);

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fprev_q, fprev_d;
  logic          mode_q, mode_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          txb_q, txb_d;
  logic          take_q, take_d;
  logic          rxd_q, rxd_d;
  logic          vld_q, vld_d;
  logic          stf_q, stf_d;

  logic          fstuff;
  logic          dstuff;
  logic          b;

  // Run length saturates one past the threshold so an RX
  // overrun keeps reading as an error without wrapping.
  function automatic logic [RW-1:0] run_step(
    input logic          bit_v,
    input logic          last,
    input logic [RW-1:0] run
  );
    if (run == '0 || bit_v != last) return RONE;
    if (run >= RMAX) return RMAX;
    return run + RONE;
  endfunction

  // Next-state and registered-output selection for one bit time.
  always_comb begin
    run_d   = run_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    fprev_d = fprev_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    txb_d   = txb_q;
    rxd_d   = rxd_q;
    take_d  = 1'b0;
    vld_d   = 1'b0;
    stf_d   = 1'b0;
    fstuff  = 1'b0;
    dstuff  = 1'b0;
    b       = mode_q ? bus.tx_bit : bus.rx_bit;

    if (!bus.enable) begin
      run_d   = '0;
      last_d  = 1'b1;
      fcnt_d  = '0;
      fprev_d = 1'b0;
      mode_d  = bus.tx_mode;
      cnt_d   = '0;
      err_d   = 1'b0;
      txb_d   = 1'b1;
    end else if (bus.sample) begin
      fprev_d = bus.fixed_mode;
      fstuff  = bus.fixed_mode &&
                (!fprev_q || fcnt_q >= FLIM);
      dstuff  = !bus.fixed_mode && run_q == RLIM;

      if (fstuff) begin
        stf_d  = 1'b1;
        fcnt_d = '0;
        run_d  = RONE;
        if (mode_q) begin
          txb_d  = ~last_q;
          last_d = ~last_q;
        end else begin
          last_d = bus.rx_bit;
          if (bus.rx_bit == last_q) err_d = 1'b1;
        end
      end else if (dstuff) begin
        if (mode_q) begin
          stf_d  = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          txb_d  = ~last_q;
          last_d = ~last_q;
          run_d  = RONE;
        end else if (bus.rx_bit != last_q) begin
          stf_d  = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          last_d = bus.rx_bit;
          run_d  = RONE;
        end else begin
          err_d  = 1'b1;
          run_d  = run_step(bus.rx_bit, last_q, run_q);
        end
      end else begin
        run_d  = run_step(b, last_q, run_q);
        last_d = b;
        fcnt_d = bus.fixed_mode ? fcnt_q + FONE : '0;
        if (mode_q) begin
          txb_d  = bus.tx_bit;
          take_d = 1'b1;
        end else begin
          rxd_d  = bus.rx_bit;
          vld_d  = 1'b1;
        end
      end
    end
  end

  // State and output registers, recessive on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= '0;
      last_q  <= 1'b1;
      fcnt_q  <= '0;
      fprev_q <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      txb_q   <= 1'b1;
      take_q  <= 1'b0;
      rxd_q   <= 1'b0;
      vld_q   <= 1'b0;
      stf_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      fprev_q <= fprev_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      txb_q   <= txb_d;
      take_q  <= take_d;
      rxd_q   <= rxd_d;
      vld_q   <= vld_d;
      stf_q   <= stf_d;
    end
  end

  assign bus.tx_bus    = txb_q;
  assign bus.tx_take   = take_q;
  assign bus.rx_data   = rxd_q;
  assign bus.rx_valid  = vld_q;
  assign bus.stuff_bit = stf_q;
  assign bus.stuff_err = err_q;
  assign bus.stuff_cnt = cnt_q;
endmodule

// File: tb/tb_can_stuff_engine.sv
// Directed bench for can_stuff_engine.
// Hand-computed bit sequences for TX, RX, fixed mode and wrap.
module tb_can_stuff_engine;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clock = ~clock;

  can_stuff_if cif ();

  can_stuff_engine #(
    .STUFF_LEN(5),
    .FIXED_LEN(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (cif)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic slot(input logic txb,
                      input logic rxb,
                      input logic fm);
    @(negedge clock);
    cif.tx_bit     = txb;
    cif.rx_bit     = rxb;
    cif.fixed_mode = fm;
    cif.sample     = 1'b1;
    @(negedge clock);
    cif.sample     = 1'b0;
  endtask

  task automatic start(input logic m);
    @(negedge clock);
    cif.enable     = 1'b0;
    cif.tx_mode    = m;
    cif.fixed_mode = 1'b0;
    @(negedge clock);
    cif.enable     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_bus[12];
    logic exp_take[12];
    logic fdat[9];
    logic rxs[7];
    logic rxv[7];
    logic rxst[7];
    logic prev;
    logic eb;
    logic es;
    int   idx;
    int   ns;

    cif.enable     = 1'b0;
    cif.sample     = 1'b0;
    cif.tx_mode    = 1'b0;
    cif.fixed_mode = 1'b0;
    cif.tx_bit     = 1'b0;
    cif.rx_bit     = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_tx_bus", cif.tx_bus, 1);
    chk("rst_tx_take", cif.tx_take, 0);
    chk("rst_rx_valid", cif.rx_valid, 0);
    chk("rst_stuff_bit", cif.stuff_bit, 0);
    chk("rst_stuff_err", cif.stuff_err, 0);
    chk("rst_stuff_cnt", cif.stuff_cnt, 0);
    reset_n = 1'b1;

    // TX six zeros: stuff 1 in slot 6
    exp_bus  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    exp_take = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    start(1'b1);
    for (int s = 0; s < 7; s++) begin
      slot(1'b0, 1'b1, 1'b0);
      chk($sformatf("tx0_bus%0d", s), cif.tx_bus, exp_bus[s]);
      chk($sformatf("tx0_take%0d", s), cif.tx_take, exp_take[s]);
      chk($sformatf("tx0_stf%0d", s), cif.stuff_bit, !exp_take[s]);
    end
    chk("tx0_cnt", cif.stuff_cnt, 1);
    @(negedge clock);
    chk("idle_take", cif.tx_take, 0);
    chk("idle_bus", cif.tx_bus, 0);
    chk("idle_cnt", cif.stuff_cnt, 1);

    // RX 1,1,1,1,1,0,1: stuff 0 removed
    rxs  = '{1, 1, 1, 1, 1, 0, 1};
    rxv  = '{1, 1, 1, 1, 1, 0, 1};
    rxst = '{0, 0, 0, 0, 0, 1, 0};
    start(1'b0);
    chk("rx1_cnt0", cif.stuff_cnt, 0);
    chk("rx1_bus_rec", cif.tx_bus, 1);
    for (int s = 0; s < 7; s++) begin
      slot(1'b0, rxs[s], 1'b0);
      chk($sformatf("rx1_vld%0d", s), cif.rx_valid, rxv[s]);
      chk($sformatf("rx1_stf%0d", s), cif.stuff_bit, rxst[s]);
      if (rxv[s]) chk($sformatf("rx1_dat%0d", s), cif.rx_data, 1);
    end
    chk("rx1_err", cif.stuff_err, 0);
    chk("rx1_cnt", cif.stuff_cnt, 1);

    // RX six zeros: stuff error on 6th
    start(1'b0);
    chk("rx0_cnt0", cif.stuff_cnt, 0);
    for (int s = 0; s < 6; s++) begin
      slot(1'b0, 1'b0, 1'b0);
      chk($sformatf("rx0_vld%0d", s), cif.rx_valid, s < 5);
      chk($sformatf("rx0_stf%0d", s), cif.stuff_bit, 0);
      chk($sformatf("rx0_err%0d", s), cif.stuff_err, s == 5);
    end
    slot(1'b0, 1'b1, 1'b0);
    chk("rx0_err_hold", cif.stuff_err, 1);
    chk("rx0_vld_after", cif.rx_valid, 1);
    @(negedge clock);
    cif.enable = 1'b0;
    @(negedge clock);
    chk("rx0_err_clr", cif.stuff_err, 0);
    chk("rx0_cnt_clr", cif.stuff_cnt, 0);

    // Fixed mode TX after data bit 1
    fdat     = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    exp_bus  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    exp_take = '{1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    start(1'b1);
    idx = 0;
    for (int s = 0; s < 12; s++) begin
      slot(fdat[idx], 1'b1, s != 0);
      chk($sformatf("fx_bus%0d", s), cif.tx_bus, exp_bus[s]);
      chk($sformatf("fx_take%0d", s), cif.tx_take, exp_take[s]);
      chk($sformatf("fx_stf%0d", s), cif.stuff_bit, !exp_take[s]);
      if (exp_take[s] && idx < 8) idx++;
    end
    chk("fx_cnt", cif.stuff_cnt, 0);

    // 9 dynamic stuff bits: count wraps to 1
    start(1'b1);
    prev = 1'b0;
    ns   = 0;
    for (int s = 1; s <= 46; s++) begin
      slot(prev, 1'b1, 1'b0);
      es = (s >= 6) && ((s - 6) % 5 == 0);
      eb = es ? ~prev : prev;
      chk($sformatf("wr_bus%0d", s), cif.tx_bus, eb);
      chk($sformatf("wr_stf%0d", s), cif.stuff_bit, es);
      prev = eb;
      if (es) ns++;
      if (s == 36) chk("wr_cnt7", cif.stuff_cnt, 7);
      if (s == 41) chk("wr_cnt0", cif.stuff_cnt, 0);
    end
    chk("wr_nstuff", ns[7:0], 9);
    chk("wr_cnt1", cif.stuff_cnt, 1);
    chk("wr_stf_pre", cif.stuff_bit, 1);

    // Async reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("ar_stf", cif.stuff_bit, 0);
    chk("ar_cnt", cif.stuff_cnt, 0);
    chk("ar_bus", cif.tx_bus, 1);
    chk("ar_take", cif.tx_take, 0);
    chk("ar_err", cif.stuff_err, 0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
